// File: rtl/split_fsm.sv
// split_fsm: address-decoded 1-to-N native-bus request demux.
// The slave index is addr[P_SLAVES -: NS]. It is captured into sel_reg in IDLE, so the chosen
// slave sees a stable request for the whole transaction. Out-of-range indices get a one-cycle
// error reply with rdata=0.
// Optional feature: define SPLIT_TIMEOUT_EN to enable a BUSY watchdog. After TIMEOUT_CYCLES
// BUSY cycles without a slave ready, the watchdog ends the transaction with rdata all ones.
// Bus packing: request = {valid, addr, wdata, wstrb}, response = {rdata, ready}.

`define REQ_W  (1 + ADDR_W + DATA_W + DATA_W / 8)
`define RESP_W (DATA_W + 1)
`define REQ_SLOT(k)  ((k) * `REQ_W) +: `REQ_W
`define RESP_SLOT(k) ((k) * `RESP_W) +: `RESP_W

module split_fsm #(
    parameter int N_SLAVES       = 2,
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 32,
    parameter int P_SLAVES       = ADDR_W - 1,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [`REQ_W-1:0]              m_req,
    output logic [`RESP_W-1:0]             m_resp,
    output logic [N_SLAVES*`REQ_W-1:0]     s_req,
    input  logic [N_SLAVES*`RESP_W-1:0]    s_resp
);

    localparam int NS      = $clog2(N_SLAVES) + (($clog2(N_SLAVES) == 0) ? 1 : 0);
    localparam int ADDR_LO = DATA_W + DATA_W / 8;   // bit position of addr[0] inside m_req

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ERR  = 2'd2
    } state_t;

    state_t state_reg, state_next;
    logic [NS-1:0]      sel_reg, sel_next;
    logic               m_valid;
    logic [NS-1:0]      sel;
    logic               sel_in_range;
    logic [`RESP_W-1:0] sel_resp;
    logic               slave_ready;
    logic               timeout_hit;
    logic               drive_slave;

    // Reject parameter sets that cannot produce a working demux.
    generate
        if (N_SLAVES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
            $error("split_fsm: N_SLAVES and TIMEOUT_CYCLES must both be >= 1");
        end
    endgenerate

    assign m_valid      = m_req[`REQ_W-1];
    assign sel          = m_req[ADDR_LO + P_SLAVES -: NS];
    assign sel_in_range = ({{(32-NS){1'b0}}, sel} < N_SLAVES);

    // Select the response slot of the latched slave. Unselected slots are never looked at.
    always_comb begin
        sel_resp = '0;
        for (int k = 0; k < N_SLAVES; k++) begin
            if (sel_reg == NS'(k)) begin
                sel_resp = s_resp[`RESP_SLOT(k)];
            end
        end
    end

    assign slave_ready = sel_resp[0];

`ifdef SPLIT_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] cnt_reg, cnt_next;

    // The watchdog fires only when no slave ready arrives in the final allowed cycle.
    assign timeout_hit = (state_reg == BUSY) && !slave_ready &&
                         (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

    // Watchdog counter: cleared on entry to BUSY, counts BUSY cycles without ready.
    always_comb begin
        cnt_next = cnt_reg;
        if (state_reg == IDLE && m_valid && sel_in_range) begin
            cnt_next = '0;
        end else if (state_reg == BUSY && !slave_ready) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    // Watchdog counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // State and latched slave index.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            sel_reg   <= '0;
        end else begin
            state_reg <= state_next;
            sel_reg   <= sel_next;
        end
    end

    // Next-state decode and master-side response.
    always_comb begin
        state_next = state_reg;
        sel_next   = sel_reg;
        m_resp     = '0;
        unique case (state_reg)
            IDLE: begin
                if (m_valid) begin
                    if (sel_in_range) begin
                        sel_next   = sel;
                        state_next = BUSY;
                    end else begin
                        state_next = ERR;
                    end
                end
            end
            BUSY: begin
                if (timeout_hit) begin
                    m_resp     = {{DATA_W{1'b1}}, 1'b1};
                    state_next = IDLE;
                end else begin
                    m_resp = sel_resp;
                    if (slave_ready) begin
                        state_next = IDLE;
                    end
                end
            end
            ERR: begin
                m_resp     = {{DATA_W{1'b0}}, 1'b1};
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Only the latched slave sees the request, and only while BUSY without a watchdog expiry.
    assign drive_slave = (state_reg == BUSY) && !timeout_hit;

    // Per-slot request fan-out.
    generate
        for (genvar gi = 0; gi < N_SLAVES; gi++) begin : g_slot
            assign s_req[`REQ_SLOT(gi)] = (drive_slave && sel_reg == NS'(gi)) ? m_req : '0;
        end
    endgenerate

endmodule

`undef REQ_SLOT
`undef RESP_SLOT
`undef REQ_W
`undef RESP_W

// File: tb/tb_split_fsm.sv
// tb_split_fsm: directed self-checking bench for split_fsm.
// Instance a: 2 slaves, TIMEOUT_CYCLES=8. Instance b: 3 slaves, used for the out-of-range decode.
module tb_split_fsm;

    localparam int RQ = 69;   // 1 + 32 + 32 + 4
    localparam int RS = 33;   // 32 + 1

    logic clk = 1'b0;
    logic rst;

    logic [RQ-1:0]   m_req_a;
    logic [RS-1:0]   m_resp_a;
    logic [2*RQ-1:0] s_req_a;
    logic [2*RS-1:0] s_resp_a;

    logic [RQ-1:0]   m_req_b;
    logic [RS-1:0]   m_resp_b;
    logic [3*RQ-1:0] s_req_b;
    logic [3*RS-1:0] s_resp_b;

    int tests = 0;
    int fails = 0;

    logic [RQ-1:0] r;

    always #5 clk = ~clk;

    split_fsm #(.N_SLAVES(2), .TIMEOUT_CYCLES(8)) dut_a (
        .clk(clk), .rst(rst), .m_req(m_req_a), .m_resp(m_resp_a),
        .s_req(s_req_a), .s_resp(s_resp_a)
    );

    split_fsm #(.N_SLAVES(3), .TIMEOUT_CYCLES(8)) dut_b (
        .clk(clk), .rst(rst), .m_req(m_req_b), .m_resp(m_resp_b),
        .s_req(s_req_b), .s_resp(s_resp_b)
    );

    function automatic logic [RQ-1:0] mk_req(input logic v, input logic [31:0] a,
                                              input logic [31:0] d, input logic [3:0] s);
        return {v, a, d, s};
    endfunction

    function automatic logic [RS-1:0] mk_resp(input logic [31:0] d);
        return {d, 1'b1};
    endfunction

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Move just past the next rising edge, then let new inputs settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        m_req_a = '0; s_resp_a = '0;
        m_req_b = '0; s_resp_b = '0;
        step(); step();
        #1;
        check("reset_mresp_a", m_resp_a, 0);
        check("reset_sreq_a", s_req_a, 0);
        check("reset_mresp_b", m_resp_b, 0);
        rst = 1'b0;

        // 1: read to slave 1, ready on the third BUSY cycle
        r = mk_req(1'b1, 32'h8000_0010, 32'h0, 4'h0);
        m_req_a = r; #1;
        check("t1_idle_sreq", s_req_a, 0);
        check("t1_idle_mresp", m_resp_a, 0);
        step();
        check("t1_slot1", s_req_a[RQ +: RQ], r);
        check("t1_slot0", s_req_a[0 +: RQ], 0);
        check("t1_wait1", m_resp_a, 0);
        step();
        check("t1_wait2", m_resp_a, 0);
        step();
        s_resp_a[RS +: RS] = mk_resp(32'hCAFE_0001); #1;
        check("t1_ready", m_resp_a, {32'hCAFE_0001, 1'b1});
        check("t1_slot0_b", s_req_a[0 +: RQ], 0);
        step();
        m_req_a = '0; s_resp_a = '0; #1;
        check("t1_done", m_resp_a, 0);
        check("t1_done_sreq", s_req_a, 0);

        // 2: write to slave 0, slave ready immediately
        r = mk_req(1'b1, 32'h0000_0004, 32'h1234_5678, 4'hF);
        m_req_a = r; #1;
        check("t2_idle", m_resp_a, 0);
        step();
        s_resp_a[0 +: RS] = mk_resp(32'hAAAA_5555); #1;
        check("t2_slot0", s_req_a[0 +: RQ], r);
        check("t2_slot1", s_req_a[RQ +: RQ], 0);
        check("t2_ready", m_resp_a, {32'hAAAA_5555, 1'b1});
        step();
        m_req_a = '0; s_resp_a = '0; #1;
        check("t2_done", m_resp_a, 0);

        // 3: three slaves, sel=3 is out of range
        m_req_b = mk_req(1'b1, 32'hC000_0000, 32'h0, 4'h0); #1;
        check("t3_idle", m_resp_b, 0);
        step();
        m_req_b = '0; #1;
        check("t3_err", m_resp_b, {32'h0, 1'b1});
        check("t3_noslave", s_req_b, 0);
        step();
        check("t3_after", m_resp_b, 0);
        r = mk_req(1'b1, 32'h8000_0000, 32'h0, 4'h0);
        m_req_b = r;
        step();
        s_resp_b[2*RS +: RS] = mk_resp(32'h0000_0222); #1;
        check("t3_slot2", s_req_b[2*RQ +: RQ], r);
        check("t3_slot2_rdy", m_resp_b, {32'h0000_0222, 1'b1});
        step();
        m_req_b = '0; s_resp_b = '0; #1;
        check("t3_done", m_resp_b, 0);

        // 4: back-to-back slave 1 then slave 0, spurious ready on slot 0 ignored
        m_req_a = mk_req(1'b1, 32'h8000_0020, 32'h0, 4'h0);
        step();
        s_resp_a[0 +: RS] = mk_resp(32'hDEAD_BEEF); #1;
        check("t4_spurious", m_resp_a, 0);
        check("t4_slot0_off", s_req_a[0 +: RQ], 0);
        step();
        s_resp_a[RS +: RS] = mk_resp(32'h1111_1111); #1;
        check("t4_ready1", m_resp_a, {32'h1111_1111, 1'b1});
        step();
        r = mk_req(1'b1, 32'h0000_0008, 32'h0BAD_F00D, 4'h3);
        m_req_a = r; s_resp_a[RS +: RS] = '0; #1;
        check("t4_idle_gap", m_resp_a, 0);
        step();
        check("t4_slot0", s_req_a[0 +: RQ], r);
        check("t4_ready0", m_resp_a, {32'hDEAD_BEEF, 1'b1});
        step();
        m_req_a = '0; s_resp_a = '0; #1;
        check("t4_done", m_resp_a, 0);

        // 5: reset while BUSY abandons the transaction
        r = mk_req(1'b1, 32'h8000_0030, 32'h0, 4'h0);
        m_req_a = r;
        step();
        check("t5_busy", s_req_a[RQ +: RQ], r);
        rst = 1'b1;
        step();
        m_req_a = '0;
        s_resp_a[RS +: RS] = mk_resp(32'h9999_9999); #1;
        check("t5_rst_mresp", m_resp_a, 0);
        check("t5_rst_sreq", s_req_a, 0);
        rst = 1'b0;
        step();
        s_resp_a = '0; #1;
        check("t5_idle", m_resp_a, 0);
        r = mk_req(1'b1, 32'h0000_000C, 32'h0, 4'h0);
        m_req_a = r;
        step();
        s_resp_a[0 +: RS] = mk_resp(32'h5A5A_5A5A); #1;
        check("t5_resume", m_resp_a, {32'h5A5A_5A5A, 1'b1});
        step();
        m_req_a = '0; s_resp_a = '0; #1;
        check("t5_done", m_resp_a, 0);

`ifdef SPLIT_TIMEOUT_EN
        // 6: watchdog expires on BUSY cycle 8
        r = mk_req(1'b1, 32'h8000_0040, 32'h0, 4'h0);
        m_req_a = r;
        for (int i = 1; i <= 7; i++) begin
            step();
            check($sformatf("t6_wait%0d", i), m_resp_a, 0);
        end
        step();
        check("t6_timeout", m_resp_a, {32'hFFFF_FFFF, 1'b1});
        check("t6_valid_off", s_req_a[RQ +: RQ], 0);
        step();
        m_req_a = '0; #1;
        check("t6_idle", m_resp_a, 0);
        // slave ready on cycle 8 beats the watchdog
        m_req_a = r;
        for (int i = 1; i <= 7; i++) begin
            step();
        end
        step();
        s_resp_a[RS +: RS] = mk_resp(32'h7777_7777); #1;
        check("t6_slave_wins", m_resp_a, {32'h7777_7777, 1'b1});
        check("t6_slot1", s_req_a[RQ +: RQ], r);
        step();
        m_req_a = '0; s_resp_a = '0; #1;
        check("t6_done", m_resp_a, 0);
`else
        // 6: without the watchdog BUSY waits as long as the slave takes
        r = mk_req(1'b1, 32'h8000_0040, 32'h0, 4'h0);
        m_req_a = r;
        for (int i = 1; i <= 12; i++) begin
            step();
            check($sformatf("t6_wait%0d", i), m_resp_a, 0);
        end
        step();
        check("t6_still_busy", s_req_a[RQ +: RQ], r);
        s_resp_a[RS +: RS] = mk_resp(32'h7777_7777); #1;
        check("t6_late_ready", m_resp_a, {32'h7777_7777, 1'b1});
        step();
        m_req_a = '0; s_resp_a = '0; #1;
        check("t6_done", m_resp_a, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
